// File: rtl/mega_mul_seq.sv
// mega_mul_seq: iterative shift-add sequencer for the MEGA multiply family
// (MUL/MULS/MULSU/FMUL/FMULS/FMULSU). It replaces the combinational 8x8
// multiplier on builds without DSP blocks. One adder/shifter datapath serves
// all six opcodes. Operands are reduced to magnitudes on entry, and sign and
// fraction correction happen in a single FIX state.
//
// Build option: MEGA_MUL_RADIX4_EN. When it is defined, RUN retires two
// multiplier bits per cycle and takes 4 cycles. When it is undefined, RUN is
// radix-2 and takes 8 cycles. Both builds give the same results and flags.
//
// Ports:
//   clk    core clock
//   rst    synchronous reset, active low
//   start  request, sampled only in IDLE
//   op     0 MUL, 1 MULS, 2 MULSU, 3 FMUL, 4 FMULS, 5 FMULSU (6/7 act as MUL)
//   rd     multiplicand, sampled with start
//   rr     multiplier, sampled with start
//   abort  flush the operation in flight (RUN/FIX only)
//   busy   high in RUN and FIX
//   done   one-cycle pulse; R/c_out/z_out are valid in that cycle
//   R      16-bit product
//   c_out  SREG.C result
//   z_out  SREG.Z result
module mega_mul_seq #(
  parameter string PLATFORM = "XILINX", // target family tag, no functional effect
  parameter bit    HOLD_RES = 1'b1      // 0: results clear the cycle after done
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [7:0]  rd,
  input  logic [7:0]  rr,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic [15:0] R,
  output logic        c_out,
  output logic        z_out
);

`ifdef MEGA_MUL_RADIX4_EN
  localparam int          CW   = 2;
  localparam logic [CW-1:0] LAST = 2'd3;
`else
  localparam int          CW   = 3;
  localparam logic [CW-1:0] LAST = 3'd7;
`endif

  // The platform string is only a tag. This empty block keeps it referenced.
  if (PLATFORM == "") begin : g_no_platform
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;
  state_t state, nxt;

  logic [7:0]    a_mag, b_mag;
  logic [15:0]   acc;
  logic [CW-1:0] cnt;
  logic          neg, frac;

  // Signedness of each operand for each opcode
  logic       rd_sgn, rr_sgn, frac_in;
  logic [7:0] a_in, b_in;
  always_comb begin
    rd_sgn  = 1'b0;
    rr_sgn  = 1'b0;
    frac_in = 1'b0;
    case (op)
      3'd1: begin rd_sgn = 1'b1; rr_sgn = 1'b1; end
      3'd2: rd_sgn = 1'b1;
      3'd3: frac_in = 1'b1;
      3'd4: begin rd_sgn = 1'b1; rr_sgn = 1'b1; frac_in = 1'b1; end
      3'd5: begin rd_sgn = 1'b1; frac_in = 1'b1; end
      default: ;
    endcase
    // The magnitude of 0x80 wraps to 0x80, which is correct as an unsigned 8-bit value.
    a_in = (rd_sgn && rd[7]) ? (8'd0 - rd) : rd;
    b_in = (rr_sgn && rr[7]) ? (8'd0 - rr) : rr;
  end

  // Add to the top half of acc, then shift right. Low product bits fall into
  // acc[7:0], so after the last step acc holds the full unsigned product.
  logic [15:0] acc_nxt;
  logic [7:0]  b_nxt;
`ifdef MEGA_MUL_RADIX4_EN
  logic [9:0] addend, sum;
  always_comb begin
    case (b_mag[1:0])
      2'd0:    addend = 10'd0;
      2'd1:    addend = {2'b00, a_mag};
      2'd2:    addend = {1'b0, a_mag, 1'b0};
      default: addend = {2'b00, a_mag} + {1'b0, a_mag, 1'b0};
    endcase
    sum     = {2'b00, acc[15:8]} + addend;
    acc_nxt = {sum, acc[7:2]};
    b_nxt   = b_mag >> 2;
  end
`else
  logic [8:0] sum;
  always_comb begin
    sum     = {1'b0, acc[15:8]} + (b_mag[0] ? {1'b0, a_mag} : 9'd0);
    acc_nxt = {sum, acc[7:1]};
    b_nxt   = b_mag >> 1;
  end
`endif

  // Sign and fraction fix-up
  logic [15:0] p, r_fix;
  always_comb begin
    p     = neg ? (16'd0 - acc) : acc;
    r_fix = frac ? {p[14:0], 1'b0} : p;
  end

  // Next-state logic
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE: if (start) nxt = S_RUN;
      S_RUN:  if (abort) nxt = S_IDLE;
              else if (cnt == LAST) nxt = S_FIX;
      S_FIX:  nxt = abort ? S_IDLE : S_DONE;
      S_DONE: nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= nxt;
  end

  assign busy = (state == S_RUN) || (state == S_FIX);
  assign done = (state == S_DONE);

  // Datapath
  always_ff @(posedge clk) begin
    if (!rst) begin
      a_mag <= '0;
      b_mag <= '0;
      acc   <= '0;
      cnt   <= '0;
      neg   <= 1'b0;
      frac  <= 1'b0;
      R     <= '0;
      c_out <= 1'b0;
      z_out <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          a_mag <= a_in;
          b_mag <= b_in;
          neg   <= (rd_sgn & rd[7]) ^ (rr_sgn & rr[7]);
          frac  <= frac_in;
          acc   <= '0;
          cnt   <= '0;
        end
        S_RUN: begin
          acc   <= acc_nxt;
          b_mag <= b_nxt;
          cnt   <= cnt + 1'b1;
        end
        // An abort leaves the previous result visible.
        S_FIX: if (!abort) begin
          R     <= r_fix;
          c_out <= p[15];
          z_out <= (r_fix == 16'd0);
        end
        S_DONE: if (!HOLD_RES) begin
          R     <= '0;
          c_out <= 1'b0;
          z_out <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mega_mul_seq.sv
// Self-checking bench for mega_mul_seq. It runs directed corner products,
// randomized opcodes and operands against a signed-integer reference model,
// and control cases (start ignored while busy, start held high, abort, and
// reset in the middle of an operation).
module tb_mega_mul_seq;
`ifdef MEGA_MUL_RADIX4_EN
  localparam int LAT = 6;
`else
  localparam int LAT = 10;
`endif

  logic        clk = 1'b0;
  logic        rst, start, abort;
  logic [2:0]  op;
  logic [7:0]  rd, rr;
  logic        busy, done, c_out, z_out;
  logic [15:0] R;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mega_mul_seq #(.PLATFORM("XILINX"), .HOLD_RES(1'b1)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .rd(rd), .rr(rr),
    .abort(abort), .busy(busy), .done(done), .R(R), .c_out(c_out), .z_out(z_out)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: plain signed/unsigned integer multiply
  task automatic model(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                       output logic [15:0] r, output logic c, output logic z);
    int sx, sy, prod;
    logic [15:0] pp;
    bit sgx, sgy, fr;
    sgx = (o == 1) || (o == 2) || (o == 4) || (o == 5);
    sgy = (o == 1) || (o == 4);
    fr  = (o == 3) || (o == 4) || (o == 5);
    sx  = sgx ? int'($signed(x)) : int'(x);
    sy  = sgy ? int'($signed(y)) : int'(y);
    prod = sx * sy;
    pp = prod[15:0];
    c = pp[15];
    r = fr ? {pp[14:0], 1'b0} : pp;
    z = (r == 16'd0);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Issue one operation from IDLE and check latency, result, flags and the pulse width.
  task automatic do_mul(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
    int cyc;
    logic [15:0] er;
    logic ec, ez;
    model(o, x, y, er, ec, ez);
    op = o; rd = x; rr = y; start = 1'b1;
    tick();
    start = 1'b0;
    op = 3'($urandom); rd = 8'($urandom); rr = 8'($urandom);
    cyc = 1;
    chk("busy_run", busy, 1'b1);
    while (!done && cyc < 40) begin tick(); cyc++; end
    chk("latency", cyc, LAT);
    chk("R", R, er);
    chk("c_out", c_out, ec);
    chk("z_out", z_out, ez);
    chk("busy_done", busy, 1'b0);
    tick();
    chk("done_pulse", done, 1'b0);
    chk("R_hold", R, er);
  endtask

  initial begin
    int first, nd;
    logic [15:0] er, keep;
    logic ec, ez;

    rst = 1'b0; start = 1'b0; abort = 1'b0; op = '0; rd = '0; rr = '0;
    repeat (3) tick();
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_R", R, 16'h0);
    chk("rst_c", c_out, 1'b0);
    chk("rst_z", z_out, 1'b0);
    rst = 1'b1;
    tick();

    // Directed corner products
    do_mul(3'd0, 8'hFF, 8'hFF); chk("mul_ff_R", R, 16'hFE01); chk("mul_ff_c", c_out, 1'b1);
    do_mul(3'd1, 8'h80, 8'h80); chk("muls_80_R", R, 16'h4000); chk("muls_80_c", c_out, 1'b0);
    do_mul(3'd2, 8'hFF, 8'h02); chk("mulsu_R", R, 16'hFFFE); chk("mulsu_c", c_out, 1'b1);
    do_mul(3'd3, 8'h80, 8'h80); chk("fmul_80_R", R, 16'h8000); chk("fmul_80_c", c_out, 1'b0);
    do_mul(3'd0, 8'h00, 8'h37); chk("mul_zero_z", z_out, 1'b1); chk("mul_zero_R", R, 16'h0);
    do_mul(3'd4, 8'h80, 8'hC0);
    do_mul(3'd5, 8'h80, 8'hFF);
    do_mul(3'd3, 8'h80, 8'h02);
    do_mul(3'd6, 8'hF0, 8'h0F);
    do_mul(3'd7, 8'h81, 8'h81);

    // Randomized opcodes and operands
    for (int i = 0; i < 40; i++)
      do_mul(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));

    // A second start while busy is ignored: one done only, carrying the first operands.
    model(3'd0, 8'h12, 8'h34, er, ec, ez);
    op = 3'd0; rd = 8'h12; rr = 8'h34; start = 1'b1;
    tick(); start = 1'b0;
    tick(); tick();
    op = 3'd1; rd = 8'h99; rr = 8'h77; start = 1'b1;
    tick(); start = 1'b0;
    first = -1; nd = 0;
    for (int cyc = 4; cyc < 30; cyc++) begin
      if (done) begin nd++; if (first < 0) first = cyc; end
      tick();
    end
    chk("ign_ndone", nd, 1);
    chk("ign_first", first, LAT);
    chk("ign_R", R, er);

    // With start held high, DONE ignores it and the next IDLE accepts it.
    op = 3'd0; rd = 8'h07; rr = 8'h09; start = 1'b1;
    tick();
    first = -1; nd = 0;
    for (int cyc = 1; cyc < 3 * LAT; cyc++) begin
      if (done) begin
        nd++;
        if (nd == 1) first = cyc;
        else begin chk("hold_second", cyc, 2 * LAT + 1); start = 1'b0; end
      end
      tick();
    end
    chk("hold_first", first, LAT);
    chk("hold_ndone", nd, 2);
    chk("hold_R", R, 16'd63);
    repeat (3) tick();

    // Abort during RUN: busy drops, no done, and the old result stays.
    keep = R;
    op = 3'd0; rd = 8'hAA; rr = 8'h55; start = 1'b1;
    tick(); start = 1'b0;
    repeat (4) tick();
    abort = 1'b1;
    tick(); abort = 1'b0;
    chk("abort_busy", busy, 1'b0);
    nd = 0;
    for (int cyc = 0; cyc < 15; cyc++) begin if (done) nd++; tick(); end
    chk("abort_ndone", nd, 0);
    chk("abort_R", R, keep);

    // Abort while IDLE has no effect.
    abort = 1'b1; tick(); abort = 1'b0;
    chk("abort_idle_busy", busy, 1'b0);
    do_mul(3'd2, 8'h85, 8'hC3);

    // Reset in the middle of an operation, then a clean operation.
    op = 3'd0; rd = 8'hFF; rr = 8'hFF; start = 1'b1;
    tick(); start = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("mrst_busy", busy, 1'b0);
    chk("mrst_done", done, 1'b0);
    chk("mrst_R", R, 16'h0);
    rst = 1'b1;
    do_mul(3'd1, 8'h7F, 8'h81);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
